// File: rtl/iosys_pkg.sv
// Shared definitions for the I/O-system SDRAM arbiter: default geometry and FSM state encoding.
package iosys_pkg;

  localparam int          ADDR_W_DEFAULT    = 23;
  localparam logic [31:0] RAM_LIMIT_DEFAULT = 32'h0080_0000;

  typedef enum logic [2:0] {
    IDLE,
    LD_WR,
    CPU_LO,
    CPU_HI,
    CPU_CAP,
    CPU_DONE
  } arb_state_e;

endpackage

// File: rtl/iosys_mem_arb.sv
// Round-robin arbiter between a 16-bit loader write port and a 32-bit CPU port
// onto a 16-bit SDRAM command interface; CPU words are split into two halves.
module iosys_mem_arb
  import iosys_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEFAULT,
  parameter logic [31:0] RAM_LIMIT = RAM_LIMIT_DEFAULT
) (
  input  logic              wclk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [15:0]       ld_data,
  output logic              ld_ready,
  input  logic              cpu_valid,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_wstrb,
  output logic              cpu_ready,
  output logic [31:0]       cpu_rdata,
  output logic [ADDR_W-1:0] sd_addr,
  output logic [15:0]       sd_din,
  output logic [1:0]        sd_ds,
  output logic              sd_rd,
  output logic              sd_wr,
  input  logic [15:0]       sd_dout,
  input  logic              sd_wait,
  output logic              busy
);

  arb_state_e        state_reg, state_next;
  logic [ADDR_W-1:0] caddr_reg, caddr_next;
  logic [31:0]       cwdata_reg, cwdata_next;
  logic [3:0]        cwstrb_reg, cwstrb_next;
  logic [31:0]       rdata_reg, rdata_next;
  logic [ADDR_W-1:0] sd_addr_reg, sd_addr_next;
  logic [15:0]       sd_din_reg, sd_din_next;
  logic [1:0]        sd_ds_reg, sd_ds_next;
  logic              sd_rd_reg, sd_rd_next;
  logic              sd_wr_reg, sd_wr_next;
  logic              ld_ready_reg, ld_ready_next;
  logic              cpu_ready_reg, cpu_ready_next;
  logic              prefer_cpu_reg, prefer_cpu_next;
  logic              cap_lo_reg, cap_lo_next;
  logic              ld_pend, cpu_pend, new_rd, cur_rd;
  logic              unused_bits;

  // A requester still seeing its ready pulse has not yet had a chance to drop valid.
  assign ld_pend  = ld_valid && !ld_ready_reg;
  assign cpu_pend = cpu_valid && (cpu_addr < RAM_LIMIT) && !cpu_ready_reg;
  assign new_rd   = (cpu_wstrb == 4'b0000);
  assign cur_rd   = (cwstrb_reg == 4'b0000);

  assign ld_ready    = ld_ready_reg;
  assign cpu_ready   = cpu_ready_reg;
  assign cpu_rdata   = rdata_reg;
  assign sd_addr     = sd_addr_reg;
  assign sd_din      = sd_din_reg;
  assign sd_ds       = sd_ds_reg;
  assign sd_rd       = sd_rd_reg;
  assign sd_wr       = sd_wr_reg;
  assign busy        = (state_reg != IDLE);
  assign unused_bits = ld_addr[0];

  always_comb begin
    state_next      = state_reg;
    caddr_next      = caddr_reg;
    cwdata_next     = cwdata_reg;
    cwstrb_next     = cwstrb_reg;
    rdata_next      = rdata_reg;
    sd_addr_next    = sd_addr_reg;
    sd_din_next     = sd_din_reg;
    sd_ds_next      = sd_ds_reg;
    sd_rd_next      = sd_rd_reg;
    sd_wr_next      = sd_wr_reg;
    ld_ready_next   = 1'b0;
    cpu_ready_next  = 1'b0;
    prefer_cpu_next = prefer_cpu_reg;
    cap_lo_next     = 1'b0;

    // Low read half arrives the cycle after its acceptance, whatever state we are in.
    if (cap_lo_reg) begin
      rdata_next[15:0] = sd_dout;
    end

    unique case (state_reg)
      IDLE: begin
        if (ld_pend && (!cpu_pend || !prefer_cpu_reg)) begin
          state_next      = LD_WR;
          sd_wr_next      = 1'b1;
          sd_addr_next    = {ld_addr[ADDR_W-1:1], 1'b0};
          sd_din_next     = ld_data;
          sd_ds_next      = 2'b11;
          prefer_cpu_next = 1'b1;
        end else if (cpu_pend) begin
          caddr_next      = cpu_addr[ADDR_W-1:0];
          cwdata_next     = cpu_wdata;
          cwstrb_next     = cpu_wstrb;
          prefer_cpu_next = 1'b0;
          sd_rd_next      = new_rd;
          sd_wr_next      = !new_rd;
          if (new_rd || (cpu_wstrb[1:0] != 2'b00)) begin
            state_next   = CPU_LO;
            sd_addr_next = {cpu_addr[ADDR_W-1:2], 2'b00};
            sd_din_next  = cpu_wdata[15:0];
            sd_ds_next   = new_rd ? 2'b11 : cpu_wstrb[1:0];
          end else begin
            state_next   = CPU_HI;
            sd_addr_next = {cpu_addr[ADDR_W-1:2], 2'b10};
            sd_din_next  = cpu_wdata[31:16];
            sd_ds_next   = cpu_wstrb[3:2];
          end
        end
      end
      LD_WR: begin
        if (!sd_wait) begin
          state_next    = IDLE;
          sd_wr_next    = 1'b0;
          ld_ready_next = 1'b1;
        end
      end
      CPU_LO: begin
        if (!sd_wait) begin
          sd_rd_next  = 1'b0;
          sd_wr_next  = 1'b0;
          cap_lo_next = cur_rd;
          if (cur_rd || (cwstrb_reg[3:2] != 2'b00)) begin
            state_next   = CPU_HI;
            sd_rd_next   = cur_rd;
            sd_wr_next   = !cur_rd;
            sd_addr_next = {caddr_reg[ADDR_W-1:2], 2'b10};
            sd_din_next  = cwdata_reg[31:16];
            sd_ds_next   = cur_rd ? 2'b11 : cwstrb_reg[3:2];
          end else begin
            state_next     = CPU_DONE;
            cpu_ready_next = 1'b1;
          end
        end
      end
      CPU_HI: begin
        if (!sd_wait) begin
          sd_rd_next = 1'b0;
          sd_wr_next = 1'b0;
          if (cur_rd) begin
            state_next = CPU_CAP;
          end else begin
            state_next     = CPU_DONE;
            cpu_ready_next = 1'b1;
          end
        end
      end
      CPU_CAP: begin
        rdata_next[31:16] = sd_dout;
        state_next        = CPU_DONE;
        cpu_ready_next    = 1'b1;
      end
      CPU_DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      caddr_reg      <= '0;
      cwdata_reg     <= '0;
      cwstrb_reg     <= '0;
      rdata_reg      <= '0;
      sd_addr_reg    <= '0;
      sd_din_reg     <= '0;
      sd_ds_reg      <= '0;
      sd_rd_reg      <= 1'b0;
      sd_wr_reg      <= 1'b0;
      ld_ready_reg   <= 1'b0;
      cpu_ready_reg  <= 1'b0;
      prefer_cpu_reg <= 1'b0;
      cap_lo_reg     <= 1'b0;
    end else begin
      state_reg      <= state_next;
      caddr_reg      <= caddr_next;
      cwdata_reg     <= cwdata_next;
      cwstrb_reg     <= cwstrb_next;
      rdata_reg      <= rdata_next;
      sd_addr_reg    <= sd_addr_next;
      sd_din_reg     <= sd_din_next;
      sd_ds_reg      <= sd_ds_next;
      sd_rd_reg      <= sd_rd_next;
      sd_wr_reg      <= sd_wr_next;
      ld_ready_reg   <= ld_ready_next;
      cpu_ready_reg  <= cpu_ready_next;
      prefer_cpu_reg <= prefer_cpu_next;
      cap_lo_reg     <= cap_lo_next;
    end
  end

endmodule

// File: tb/tb_iosys_mem_arb.sv
// Scoreboard bench for iosys_mem_arb: expected SDRAM commands and ready pulses are
// queued at stimulus time and consumed by an independent negedge monitor.
module tb_iosys_mem_arb;

  typedef struct {
    logic        rd;
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
    int          hold;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic        chk;
    logic [31:0] rdata;
  } cpu_exp_t;

  logic        wclk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic [22:0] ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        ld_ready;
  logic        cpu_valid = 1'b0;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [3:0]  cpu_wstrb = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic [22:0] sd_addr;
  logic [15:0] sd_din;
  logic [1:0]  sd_ds;
  logic        sd_rd;
  logic        sd_wr;
  logic [15:0] sd_dout = 16'h5A5A;
  logic        sd_wait = 1'b0;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int cpu_seen = 0;
  int ld_seen = 0;

  cmd_t     exp_cmd[$];
  cpu_exp_t exp_cpu[$];
  int       exp_ld[$];

  iosys_mem_arb dut (
    .wclk(wclk), .reset(reset),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .cpu_valid(cpu_valid), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_ds(sd_ds), .sd_rd(sd_rd), .sd_wr(sd_wr),
    .sd_dout(sd_dout), .sd_wait(sd_wait), .busy(busy)
  );

  always #5 wclk = ~wclk;
  always @(posedge wclk) cyc <= cyc + 1;

  function automatic logic [15:0] mem_rd(input logic [22:0] a);
    if (a == 23'h100) return 16'h1234;
    if (a == 23'h102) return 16'hABCD;
    return {a[7:0], ~a[7:0]};
  endfunction

  // SDRAM model: read data appears the cycle after the accepting edge.
  always @(posedge wclk) begin
    if (sd_rd && !sd_wait) sd_dout <= mem_rd(sd_addr);
    else                   sd_dout <= 16'h5A5A;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_cmd(input logic rd, input logic [22:0] a, input logic [15:0] d,
                                   input logic [1:0] ds, input int hold);
    cmd_t c;
    c.rd = rd; c.addr = a; c.din = d; c.ds = ds; c.hold = hold;
    exp_cmd.push_back(c);
  endfunction

  function automatic void push_cpu(input int c, input logic k, input logic [31:0] r);
    cpu_exp_t e;
    e.cyc = c; e.chk = k; e.rdata = r;
    exp_cpu.push_back(e);
  endfunction

  task automatic wait_cpu();
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge wclk);
      seen = cpu_ready;
    end
    if (!seen) chk("cpu_ready_timeout", 32'd0, 32'd1);
    @(posedge wclk); #1;
  endtask

  task automatic wait_ld();
    bit seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge wclk);
      seen = ld_ready;
    end
    if (!seen) chk("ld_ready_timeout", 32'd0, 32'd1);
    @(posedge wclk); #1;
  endtask

  task automatic cpu_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                         input int lat, input logic [31:0] rexp);
    @(posedge wclk); #1;
    cpu_addr = a; cpu_wdata = wd; cpu_wstrb = ws; cpu_valid = 1'b1;
    push_cpu(cyc + lat, (ws == 4'b0000), rexp);
    wait_cpu();
    cpu_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rd_wr"}, 32'({sd_rd, sd_wr, ld_ready, cpu_ready}), 32'd0);
    chk({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
    chk({tag, "_din_ds"}, 32'({sd_din, sd_ds}), 32'd0);
    chk({tag, "_rdata"}, cpu_rdata, 32'd0);
  endtask

  initial begin : monitor
    int       hold = 0;
    cpu_exp_t e;
    int       lc;
    forever begin
      @(negedge wclk);
      if (reset) begin
        hold = 0;
      end else begin
        if (sd_rd || sd_wr) begin
          hold++;
          chk("rd_wr_exclusive", 32'(sd_rd & sd_wr), 32'd0);
          if (exp_cmd.size() == 0) begin
            chk("unexpected_cmd", 32'({sd_rd, sd_wr, sd_addr}), 32'd0);
          end else begin
            chk("cmd_rd", 32'(sd_rd), 32'(exp_cmd[0].rd));
            chk("cmd_addr", 32'(sd_addr), 32'(exp_cmd[0].addr));
            if (!exp_cmd[0].rd) chk("cmd_din", 32'(sd_din), 32'(exp_cmd[0].din));
            chk("cmd_ds", 32'(sd_ds), 32'(exp_cmd[0].ds));
            if (!sd_wait) begin
              chk("cmd_hold", 32'(hold), 32'(exp_cmd[0].hold));
              void'(exp_cmd.pop_front());
            end
          end
          if (!sd_wait) hold = 0;
        end
        if (cpu_ready) begin
          cpu_seen++;
          if (exp_cpu.size() == 0) begin
            chk("unexpected_cpu_ready", 32'd1, 32'd0);
          end else begin
            e = exp_cpu.pop_front();
            chk("cpu_ready_cycle", 32'(cyc), 32'(e.cyc));
            if (e.chk) chk("cpu_rdata", cpu_rdata, e.rdata);
          end
        end
        if (ld_ready) begin
          ld_seen++;
          if (exp_ld.size() == 0) begin
            chk("unexpected_ld_ready", 32'd1, 32'd0);
          end else begin
            lc = exp_ld.pop_front();
            chk("ld_ready_cycle", 32'(cyc), 32'(lc));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin : stimulus
    int n0;
    int busy_cycles;
    logic [31:0] unclaimed [2];
    unclaimed[0] = 32'h0080_0000;
    unclaimed[1] = 32'hFFFF_FFF0;

    #1 reset = 1'b1;
    repeat (2) @(posedge wclk);
    #1 check_zero("reset");
    #2 reset = 1'b0;
    repeat (2) @(posedge wclk);

    // Reads: low half then high half, rdata assembled high:low.
    push_cmd(1'b1, 23'h100, 16'h0, 2'b11, 1);
    push_cmd(1'b1, 23'h102, 16'h0, 2'b11, 1);
    cpu_req(32'h0000_0100, 32'h0, 4'b0000, 4, 32'hABCD_1234);
    push_cmd(1'b1, 23'h7FFFFC, 16'h0, 2'b11, 1);
    push_cmd(1'b1, 23'h7FFFFE, 16'h0, 2'b11, 1);
    cpu_req(32'h007F_FFFC, 32'h0, 4'b0000, 4, 32'hFE01_FC03);

    // Writes: skipped low half, full word, mixed byte strobes.
    push_cmd(1'b0, 23'h302, 16'hDEAD, 2'b11, 1);
    cpu_req(32'h0000_0300, 32'hDEAD_0000, 4'b1100, 2, 32'h0);
    push_cmd(1'b0, 23'h404, 16'h7788, 2'b11, 1);
    push_cmd(1'b0, 23'h406, 16'h5566, 2'b11, 1);
    cpu_req(32'h0000_0405, 32'h5566_7788, 4'b1111, 3, 32'h0);

    // Loader write stalled by sd_wait for three cycles.
    @(posedge wclk); #1;
    n0 = cyc;
    ld_addr = 23'h1235; ld_data = 16'hCAFE; ld_valid = 1'b1; sd_wait = 1'b1;
    push_cmd(1'b0, 23'h1234, 16'hCAFE, 2'b11, 4);
    exp_ld.push_back(n0 + 5);
    repeat (4) @(posedge wclk);
    #1 sd_wait = 1'b0;
    wait_ld();
    ld_valid = 1'b0;

    push_cmd(1'b0, 23'h500, 16'h3344, 2'b10, 1);
    push_cmd(1'b0, 23'h502, 16'h1122, 2'b01, 1);
    cpu_req(32'h0000_0500, 32'h1122_3344, 4'b0110, 3, 32'h0);

    // Addresses at or above the RAM limit are never claimed.
    foreach (unclaimed[i]) begin
      @(posedge wclk); #1;
      cpu_addr = unclaimed[i]; cpu_wstrb = 4'b0000; cpu_valid = 1'b1;
      busy_cycles = 0;
      repeat (10) begin
        @(negedge wclk);
        if (busy || cpu_ready || sd_rd || sd_wr) busy_cycles++;
      end
      chk("unclaimed_activity", 32'(busy_cycles), 32'd0);
      @(posedge wclk); #1 cpu_valid = 1'b0;
    end

    // Reset while the high half of a write is stalled.
    sd_wait = 1'b1;
    @(posedge wclk); #1;
    cpu_addr = 32'h0000_0600; cpu_wdata = 32'h7777_0000; cpu_wstrb = 4'b1100; cpu_valid = 1'b1;
    push_cmd(1'b0, 23'h602, 16'h7777, 2'b11, 99);
    @(posedge wclk); #3;
    chk("cpu_hi_busy", 32'({busy, sd_wr}), 32'b11);
    reset = 1'b1;
    #1 check_zero("async_reset");
    exp_cmd.delete();
    cpu_valid = 1'b0;
    repeat (2) @(posedge wclk);
    #3 reset = 1'b0;
    sd_wait = 1'b0;
    repeat (8) @(posedge wclk);

    // Both requesters held: loader first after reset, then strict alternation.
    @(posedge wclk); #1;
    n0 = cyc;
    ld_addr = 23'h2000; ld_data = 16'h1111; ld_valid = 1'b1;
    cpu_addr = 32'h0000_3000; cpu_wdata = 32'hA1A2_B1B2; cpu_wstrb = 4'b1111; cpu_valid = 1'b1;
    push_cmd(1'b0, 23'h2000, 16'h1111, 2'b11, 1);
    push_cmd(1'b0, 23'h3000, 16'hB1B2, 2'b11, 1);
    push_cmd(1'b0, 23'h3002, 16'hA1A2, 2'b11, 1);
    push_cmd(1'b0, 23'h2002, 16'h2222, 2'b11, 1);
    push_cmd(1'b0, 23'h3010, 16'hD1D2, 2'b11, 1);
    push_cmd(1'b0, 23'h3012, 16'hC1C2, 2'b11, 1);
    exp_ld.push_back(n0 + 2);
    exp_ld.push_back(n0 + 8);
    push_cpu(n0 + 5, 1'b0, 32'h0);
    push_cpu(n0 + 11, 1'b0, 32'h0);
    fork
      begin
        wait_ld();
        ld_addr = 23'h2002; ld_data = 16'h2222;
        wait_ld();
        ld_valid = 1'b0;
      end
      begin
        wait_cpu();
        cpu_addr = 32'h0000_3010; cpu_wdata = 32'hC1C2_D1D2;
        wait_cpu();
        cpu_valid = 1'b0;
      end
    join

    repeat (5) @(posedge wclk);
    #1;
    chk("cmd_queue_drained", 32'(exp_cmd.size()), 32'd0);
    chk("cpu_queue_drained", 32'(exp_cpu.size()), 32'd0);
    chk("ld_queue_drained", 32'(exp_ld.size()), 32'd0);
    chk("cpu_ready_count", 32'(cpu_seen), 32'd7);
    chk("ld_ready_count", 32'(ld_seen), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
